// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the byte-wide memory port arbiter: FSM state
//   encoding, LSB access size encoding, requester IDs, the default IO region
//   selector and small byte helpers used by the arbiter.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Value of addr[17:16] that marks the memory-mapped IO region.
  localparam logic [1:0] IO_ADDR_HI_DEFAULT = 2'b11;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // LSB access size encoding (2'd3 is illegal and handled as a word).
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Requester that owns the transaction in flight.
  typedef enum logic {
    OWN_IC  = 1'b0,
    OWN_LSB = 1'b1
  } owner_t;

  // Number of bytes moved for an LSB size code.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Little-endian byte lane select: lane 0 is w[7:0].
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [2:0] idx);
    logic [7:0] b;
    case (idx[1:0])
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the byte-wide RAM/IO pins and the ICache / LSB request channels
//   of the memory arbiter.
//
//   Handshake: a requester raises *_query_en with its address (and for the
//   LSB wr/size/data) and keeps them stable until it sees its *_data_en
//   pulse for exactly one cycle; it must drop *_query_en on that cycle.
//   The arbiter does not accept a new request in the cycle after a pulse.
//
//   Modports
//     slave  : the arbiter (drives mem_* outputs, data_en/data, state_dbg)
//     master : the surrounding system (RAM, IO, ICache, LSB)
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // RAM / IO pins
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  // ICache channel
  logic        IC_query_en;
  logic [31:0] IC_query_addr;
  logic        IC_data_en;
  logic [31:0] IC_data;

  // LSB channel
  logic        LSB_query_en;
  logic        LSB_query_wr;
  logic [1:0]  LSB_query_size;
  logic [31:0] LSB_query_addr;
  logic [31:0] LSB_query_data;
  logic        LSB_data_en;
  logic [31:0] LSB_data;

  // Current arbiter FSM state, for observation only
  state_t      state_dbg;

  modport slave (
    input  mem_din, io_buffer_full,
    input  IC_query_en, IC_query_addr,
    input  LSB_query_en, LSB_query_wr, LSB_query_size, LSB_query_addr, LSB_query_data,
    output mem_dout, mem_a, mem_wr,
    output IC_data_en, IC_data,
    output LSB_data_en, LSB_data,
    output state_dbg
  );

  modport master (
    output mem_din, io_buffer_full,
    output IC_query_en, IC_query_addr,
    output LSB_query_en, LSB_query_wr, LSB_query_size, LSB_query_addr, LSB_query_data,
    input  mem_dout, mem_a, mem_wr,
    input  IC_data_en, IC_data,
    input  LSB_data_en, LSB_data,
    input  state_dbg
  );

endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Sole owner of the byte-wide RAM/IO port. Arbitrates ICache block fetches
//   (4-byte reads) against LSB loads/stores (1/2/4 bytes) with a one-bit
//   round-robin, then sequences the winner as back-to-back single-byte RAM
//   cycles and returns little-endian assembled words.
//
//   Ports
//     clk_in        clock
//     rst_in        asynchronous active-high reset
//     rdy_in        0 = pause: all state and outputs hold
//     flush_signal  mispredict flush (aborts ICache reads only)
//     bus           mem_arbiter_if.slave: RAM pins, IC and LSB channels,
//                   state_dbg
//
//   Parameter
//     IO_ADDR_HI    addr[17:16] value of the IO region; writes there wait
//                   while io_buffer_full is high
//
//   Read timing: the RAM returns mem_din one cycle after mem_a, so byte j of
//   a read is captured two edges after its address was launched. k counts
//   edges since the accept edge; bytes are launched while k < n, captured
//   when k >= 2 and the transaction completes on k == n + 1.
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEFAULT
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush_signal,
  mem_arbiter_if.slave  bus
);

  // FSM and transaction registers
  state_t      state;
  owner_t      owner;
  owner_t      last_grant;
  logic [31:0] base;
  logic [2:0]  n;
  logic [2:0]  k;
  logic [31:0] wdata;
  logic [23:0] byte_buf;

  // Registered outputs
  logic [31:0] mem_a_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q;
  logic        ic_en_q;
  logic [31:0] ic_data_q;
  logic        lsb_en_q;
  logic [31:0] lsb_data_q;

  // Arbitration: a flush masks the ICache request for that edge.
  logic ic_req;
  logic lsb_req;
  logic grant_lsb;

  assign ic_req    = bus.IC_query_en && !flush_signal;
  assign lsb_req   = bus.LSB_query_en;
  assign grant_lsb = lsb_req && (!ic_req || (last_grant == OWN_IC));

  // Write path: target of the byte about to be presented and its IO stall.
  logic [31:0] wr_addr;
  logic        wr_stall;
  logic        e0_stall;
  logic [2:0]  n_plus1;

  assign wr_addr  = base + 32'(k);
  assign wr_stall = (wr_addr[17:16] == IO_ADDR_HI) && bus.io_buffer_full;
  assign e0_stall = (bus.LSB_query_addr[17:16] == IO_ADDR_HI) && bus.io_buffer_full;
  assign n_plus1  = n + 3'd1;

  // Final word: the last byte comes straight from mem_din, the earlier ones
  // from the capture buffer; bytes above the access size are zero.
  function automatic logic [31:0] assemble(input logic [23:0] b,
                                           input logic [7:0]  last,
                                           input logic [2:0]  nb);
    logic [31:0] w;
    case (nb)
      3'd1:    w = {24'h0, last};
      3'd2:    w = {16'h0, last, b[7:0]};
      default: w = {last, b};
    endcase
    return w;
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      owner      <= OWN_IC;
      last_grant <= OWN_IC;
      base       <= '0;
      n          <= '0;
      k          <= '0;
      wdata      <= '0;
      byte_buf   <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      ic_en_q    <= 1'b0;
      ic_data_q  <= '0;
      lsb_en_q   <= 1'b0;
      lsb_data_q <= '0;
    end else if (rdy_in) begin
      case (state)
        ST_IDLE: begin
          if (grant_lsb) begin
            owner      <= OWN_LSB;
            last_grant <= OWN_LSB;
            base       <= bus.LSB_query_addr;
            n          <= size_bytes(bus.LSB_query_size);
            wdata      <= bus.LSB_query_data;
            mem_a_q    <= bus.LSB_query_addr;
            if (bus.LSB_query_wr) begin
              // Byte 0 goes out on the accept edge unless the IO FIFO is full.
              state      <= ST_WRITE;
              mem_dout_q <= bus.LSB_query_data[7:0];
              if (e0_stall) begin
                mem_wr_q <= 1'b0;
                k        <= 3'd0;
              end else begin
                mem_wr_q <= 1'b1;
                k        <= 3'd1;
              end
            end else begin
              state <= ST_READ;
              k     <= 3'd1;
            end
          end else if (ic_req) begin
            owner      <= OWN_IC;
            last_grant <= OWN_IC;
            base       <= bus.IC_query_addr;
            n          <= 3'd4;
            mem_a_q    <= bus.IC_query_addr;
            state      <= ST_READ;
            k          <= 3'd1;
          end
        end

        ST_READ: begin
          if ((owner == OWN_IC) && flush_signal) begin
            // Fetch aborted: no pulse, port returns to rest.
            state   <= ST_IDLE;
            mem_a_q <= '0;
            k       <= 3'd0;
          end else if (k == n_plus1) begin
            if (owner == OWN_IC) begin
              ic_en_q   <= 1'b1;
              ic_data_q <= assemble(byte_buf, bus.mem_din, n);
            end else begin
              lsb_en_q   <= 1'b1;
              lsb_data_q <= assemble(byte_buf, bus.mem_din, n);
            end
            mem_a_q <= '0;
            state   <= ST_DONE;
          end else begin
            if (k < n) begin
              mem_a_q <= base + 32'(k);
            end
            case (k)
              3'd2:    byte_buf[7:0]   <= bus.mem_din;
              3'd3:    byte_buf[15:8]  <= bus.mem_din;
              3'd4:    byte_buf[23:16] <= bus.mem_din;
              default: ;
            endcase
            k <= k + 3'd1;
          end
        end

        ST_WRITE: begin
          if (k < n) begin
            mem_a_q    <= wr_addr;
            mem_dout_q <= pick_byte(wdata, k);
            if (wr_stall) begin
              mem_wr_q <= 1'b0;
            end else begin
              mem_wr_q <= 1'b1;
              k        <= k + 3'd1;
            end
          end else begin
            mem_wr_q   <= 1'b0;
            mem_a_q    <= '0;
            lsb_en_q   <= 1'b1;
            lsb_data_q <= '0;
            state      <= ST_DONE;
          end
        end

        ST_DONE: begin
          ic_en_q  <= 1'b0;
          lsb_en_q <= 1'b0;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_a       = mem_a_q;
  assign bus.mem_dout    = mem_dout_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.IC_data_en  = ic_en_q;
  assign bus.IC_data     = ic_data_q;
  assign bus.LSB_data_en = lsb_en_q;
  assign bus.LSB_data    = lsb_data_q;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed steps followed by randomized fetch/load/store traffic. A shadow
//   byte memory predicts every load/fetch word and every RAM write; latency
//   and grant order are predicted from the transaction rules.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .rdy_in      (rdy),
    .flush_signal(flush),
    .bus         (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- RAM environment and write monitor ----------------
  logic [7:0]  ram       [0:262143];
  logic [7:0]  model_mem [0:262143];
  logic [39:0] wr_log[$];
  logic [39:0] exp_q[$];
  owner_t      model_last;

  // The RAM pauses with the rest of the system when rdy is low.
  always @(posedge clk) begin
    if (rdy) begin
      if (bus.mem_wr) begin
        ram[bus.mem_a[17:0]] <= bus.mem_dout;
        wr_log.push_back({bus.mem_a, bus.mem_dout});
      end
      bus.mem_din <= ram[bus.mem_a[17:0]];
    end
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'd0) return 1;
    if (sz == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input int nb);
    logic [31:0] w;
    logic [31:0] ai;
    w = '0;
    for (int i = 0; i < nb; i++) begin
      ai = a + 32'(i);
      w[8*i +: 8] = model_mem[ai[17:0]];
    end
    return w;
  endfunction

  task automatic model_store(input logic [31:0] a, input int nb, input logic [31:0] d);
    logic [31:0] ai;
    for (int i = 0; i < nb; i++) begin
      ai = a + 32'(i);
      exp_q.push_back({ai, d[8*i +: 8]});
      model_mem[ai[17:0]] = d[8*i +: 8];
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    logic [39:0] g;
    logic [39:0] e;
    chk({tag, "_wr_count"}, 64'(wr_log.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && wr_log.size() > 0) begin
      g = wr_log.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_wr"}, 64'(g), 64'(e));
    end
    wr_log.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_txn(input logic is_ic, input logic wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] got, output int lat);
    logic done;
    done = 1'b0;
    got  = '0;
    lat  = 0;
    @(negedge clk);
    if (is_ic) begin
      bus.IC_query_en   = 1'b1;
      bus.IC_query_addr = addr;
    end else begin
      bus.LSB_query_en   = 1'b1;
      bus.LSB_query_wr   = wr;
      bus.LSB_query_size = sz;
      bus.LSB_query_addr = addr;
      bus.LSB_query_data = data;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (is_ic ? bus.IC_data_en : bus.LSB_data_en) begin
        done = 1'b1;
        got  = is_ic ? bus.IC_data : bus.LSB_data;
      end
    end
    bus.IC_query_en  = 1'b0;
    bus.LSB_query_en = 1'b0;
    chk("txn_done", 64'(done), 64'd1);
    model_last = is_ic ? OWN_IC : OWN_LSB;
  endtask

  // Both requesters raise together; checks the round-robin winner and data.
  task automatic both_round(input logic [31:0] ia, input logic [31:0] la);
    owner_t exp_first;
    owner_t first;
    logic   have_first;
    logic   seen_ic;
    logic   seen_lsb;
    exp_first  = (model_last == OWN_IC) ? OWN_LSB : OWN_IC;
    first      = OWN_IC;
    have_first = 1'b0;
    seen_ic    = 1'b0;
    seen_lsb   = 1'b0;
    @(negedge clk);
    bus.IC_query_en    = 1'b1;
    bus.IC_query_addr  = ia;
    bus.LSB_query_en   = 1'b1;
    bus.LSB_query_wr   = 1'b0;
    bus.LSB_query_size = SZ_W;
    bus.LSB_query_addr = la;
    for (int c = 0; c < 40 && !(seen_ic && seen_lsb); c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.IC_data_en) begin
        seen_ic = 1'b1;
        bus.IC_query_en = 1'b0;
        chk("rr_ic_data", 64'(bus.IC_data), 64'(model_load(ia, 4)));
        if (!have_first) begin first = OWN_IC; have_first = 1'b1; end
      end
      if (bus.LSB_data_en) begin
        seen_lsb = 1'b1;
        bus.LSB_query_en = 1'b0;
        chk("rr_lsb_data", 64'(bus.LSB_data), 64'(model_load(la, 4)));
        if (!have_first) begin first = OWN_LSB; have_first = 1'b1; end
      end
    end
    bus.IC_query_en  = 1'b0;
    bus.LSB_query_en = 1'b0;
    chk("rr_both_done", 64'({seen_ic, seen_lsb}), 64'(2'b11));
    chk("rr_first", 64'(first), 64'(exp_first));
    model_last = (exp_first == OWN_IC) ? OWN_LSB : OWN_IC;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] got;
    logic [31:0] exp_w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    int          lat;
    int          kind;
    int          nb;
    logic        seen;
    logic        done;

    bus.io_buffer_full = 1'b0;
    bus.IC_query_en    = 1'b0;
    bus.IC_query_addr  = '0;
    bus.LSB_query_en   = 1'b0;
    bus.LSB_query_wr   = 1'b0;
    bus.LSB_query_size = '0;
    bus.LSB_query_addr = '0;
    bus.LSB_query_data = '0;
    bus.mem_din        = '0;

    for (int i = 0; i < 262144; i++) begin
      ram[i]       = 8'($urandom);
      model_mem[i] = ram[i];
    end
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    model_mem[32'h100] = 8'h11; model_mem[32'h101] = 8'h22;
    model_mem[32'h102] = 8'h33; model_mem[32'h103] = 8'h44;
    ram[32'h205] = 8'hF0;
    model_mem[32'h205] = 8'hF0;

    // Reset
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_a",   64'(bus.mem_a), 64'd0);
    chk("rst_mem_wr",  64'(bus.mem_wr), 64'd0);
    chk("rst_ic_en",   64'(bus.IC_data_en), 64'd0);
    chk("rst_lsb_en",  64'(bus.LSB_data_en), 64'd0);
    chk("rst_state",   64'(bus.state_dbg), 64'(ST_IDLE));
    model_last = OWN_IC;

    // Round-robin straight out of reset: LSB first, then strict alternation
    for (int r = 0; r < 4; r++) begin
      both_round(32'h400 + 32'(16 * r), 32'h800 + 32'(16 * r));
    end

    // ICache fetch of 0x100: four consecutive addresses, one pulse
    @(negedge clk);
    bus.IC_query_en   = 1'b1;
    bus.IC_query_addr = 32'h100;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      @(negedge clk);
      chk("fetch_addr", 64'(bus.mem_a), 64'(32'h100 + 32'(e)));
    end
    @(posedge clk);
    @(negedge clk);
    chk("fetch_not_yet", 64'(bus.IC_data_en), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("fetch_en", 64'(bus.IC_data_en), 64'd1);
    chk("fetch_data", 64'(bus.IC_data), 64'(32'h44332211));
    bus.IC_query_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("fetch_one_pulse", 64'(bus.IC_data_en), 64'd0);
    model_last = OWN_IC;

    // LSB loads
    run_txn(1'b0, 1'b0, SZ_B, 32'h205, 32'h0, got, lat);
    chk("load_b_data", 64'(got), 64'(32'h000000F0));
    chk("load_b_lat", 64'(lat), 64'd3);
    run_txn(1'b0, 1'b0, SZ_H, 32'h204, 32'h0, got, lat);
    chk("load_h_hi", 64'(got[31:8]), 64'(24'h0000F0));
    chk("load_h_data", 64'(got), 64'(model_load(32'h204, 2)));
    chk("load_h_lat", 64'(lat), 64'd4);

    // Word store
    wr_log.delete();
    model_store(32'h40, 4, 32'hDEADBEEF);
    run_txn(1'b0, 1'b1, SZ_W, 32'h40, 32'hDEADBEEF, got, lat);
    chk("store_w_data", 64'(got), 64'd0);
    chk("store_w_lat", 64'(lat), 64'd5);
    check_writes("store_w");

    // IO store with io_buffer_full for three edges
    wr_log.delete();
    @(negedge clk);
    bus.io_buffer_full = 1'b1;
    bus.LSB_query_en   = 1'b1;
    bus.LSB_query_wr   = 1'b1;
    bus.LSB_query_size = SZ_B;
    bus.LSB_query_addr = 32'h30000;
    bus.LSB_query_data = 32'h0000005A;
    seen = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | bus.mem_wr;
    end
    chk("io_stall_no_wr", 64'(seen), 64'd0);
    bus.io_buffer_full = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("io_wr", 64'(bus.mem_wr), 64'd1);
    chk("io_wr_addr", 64'(bus.mem_a), 64'(32'h30000));
    @(posedge clk);
    @(negedge clk);
    chk("io_done_en", 64'(bus.LSB_data_en), 64'd1);
    chk("io_done_wr_low", 64'(bus.mem_wr), 64'd0);
    bus.LSB_query_en = 1'b0;
    chk("io_wr_count", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() > 0) chk("io_wr_entry", 64'(wr_log[0]), 64'({32'h30000, 8'h5A}));
    wr_log.delete();
    model_mem[18'h30000] = 8'h5A;
    model_last = OWN_LSB;

    // Flush two cycles into a fetch
    @(negedge clk);
    bus.IC_query_en   = 1'b1;
    bus.IC_query_addr = 32'h180;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("flush_idle", 64'(bus.state_dbg), 64'(ST_IDLE));
    chk("flush_mem_a", 64'(bus.mem_a), 64'd0);
    flush = 1'b0;
    bus.IC_query_en = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | bus.IC_data_en;
    end
    chk("flush_no_pulse", 64'(seen), 64'd0);
    model_last = OWN_IC;

    // Flush while an IC request waits in IDLE: not accepted
    @(negedge clk);
    bus.IC_query_en = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("flush_blocks_accept", 64'(bus.state_dbg), 64'(ST_IDLE));
    flush = 1'b0;
    bus.IC_query_en = 1'b0;

    // Flush during an LSB load: load completes normally
    @(negedge clk);
    bus.LSB_query_en   = 1'b1;
    bus.LSB_query_wr   = 1'b0;
    bus.LSB_query_size = SZ_W;
    bus.LSB_query_addr = 32'h1234;
    lat  = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      flush = (lat == 2);
      if (bus.LSB_data_en) begin
        done = 1'b1;
        got  = bus.LSB_data;
      end
    end
    flush = 1'b0;
    bus.LSB_query_en = 1'b0;
    chk("flush_load_done", 64'(done), 64'd1);
    chk("flush_load_data", 64'(got), 64'(model_load(32'h1234, 4)));
    chk("flush_load_lat", 64'(lat), 64'd6);
    model_last = OWN_LSB;

    // Pause three cycles mid-fetch
    @(negedge clk);
    bus.IC_query_en   = 1'b1;
    bus.IC_query_addr = 32'h2A0;
    lat = 0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    rdy = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      chk("pause_hold_a", 64'(bus.mem_a), 64'(32'h2A1));
    end
    rdy  = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (bus.IC_data_en) begin
        done = 1'b1;
        got  = bus.IC_data;
      end
    end
    bus.IC_query_en = 1'b0;
    chk("pause_done", 64'(done), 64'd1);
    chk("pause_data", 64'(got), 64'(model_load(32'h2A0, 4)));
    chk("pause_lat", 64'(lat), 64'd9);
    model_last = OWN_IC;

    // Address wrap-around
    run_txn(1'b1, 1'b0, SZ_W, 32'hFFFFFFFE, 32'h0, got, lat);
    chk("wrap_fetch", 64'(got), 64'(model_load(32'hFFFFFFFE, 4)));
    wr_log.delete();
    model_store(32'hFFFFFFFF, 2, 32'h0000A55A);
    run_txn(1'b0, 1'b1, SZ_H, 32'hFFFFFFFF, 32'h0000A55A, got, lat);
    chk("wrap_store_lat", 64'(lat), 64'd3);
    check_writes("wrap_store");

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      a    = $urandom_range(0, 32'h1FFF0);
      sz   = 2'($urandom_range(0, 3));
      d    = $urandom;
      nb   = nbytes(sz);
      if (kind == 0) begin
        exp_w = model_load(a, 4);
        run_txn(1'b1, 1'b0, SZ_W, a, 32'h0, got, lat);
        chk("rnd_fetch_data", 64'(got), 64'(exp_w));
        chk("rnd_fetch_lat", 64'(lat), 64'd6);
      end else if (kind == 1) begin
        exp_w = model_load(a, nb);
        run_txn(1'b0, 1'b0, sz, a, 32'h0, got, lat);
        chk("rnd_load_data", 64'(got), 64'(exp_w));
        chk("rnd_load_lat", 64'(lat), 64'(nb + 2));
      end else begin
        wr_log.delete();
        model_store(a, nb, d);
        run_txn(1'b0, 1'b1, sz, a, d, got, lat);
        chk("rnd_store_data", 64'(got), 64'd0);
        chk("rnd_store_lat", 64'(lat), 64'(nb + 1));
        check_writes("rnd_store");
      end
    end

    // Reset pulsed between edges during a store
    @(negedge clk);
    bus.LSB_query_en   = 1'b1;
    bus.LSB_query_wr   = 1'b1;
    bus.LSB_query_size = SZ_W;
    bus.LSB_query_addr = 32'h2FF00;
    bus.LSB_query_data = 32'h01020304;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_store_wr", 64'(bus.mem_wr), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wr", 64'(bus.mem_wr), 64'd0);
    chk("async_rst_a", 64'(bus.mem_a), 64'd0);
    chk("async_rst_dout", 64'(bus.mem_dout), 64'd0);
    chk("async_rst_state", 64'(bus.state_dbg), 64'(ST_IDLE));
    bus.LSB_query_en = 1'b0;
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | bus.LSB_data_en | bus.mem_wr;
    end
    chk("rst_store_abandoned", 64'(seen), 64'd0);
    wr_log.delete();
    model_last = OWN_IC;
    both_round(32'h600, 32'h700);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
